// File: rtl/imm_gen_unit.sv
// Immediate generator with an in-order result FIFO and a saturating invalid-format counter.
// Optional IMM_AUTO_DECODE_EN: derive the format from the opcode instead of imm_src.
module imm_gen_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [2:0]               imm_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          imm,
    output logic                     imm_err,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               err_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_J   = 3'd3,
        FMT_U   = 3'd4,
        FMT_BAD = 3'd5
    } fmt_t;

    fmt_t              w_fmt;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm_ext;
    logic [XLEN:0]     w_head;
    logic              w_push;
    logic              w_pop;

    logic [XLEN:0]     r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [FW-1:0]     r_fill;
    logic [7:0]        r_err_cnt;

`ifdef IMM_AUTO_DECODE_EN
    logic w_unused_src;
    assign w_unused_src = ^imm_src;

    always_comb begin
        w_fmt = FMT_BAD;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: w_fmt = FMT_I;
            7'b0100011:                                     w_fmt = FMT_S;
            7'b1100011:                                     w_fmt = FMT_B;
            7'b1101111:                                     w_fmt = FMT_J;
            7'b0110111, 7'b0010111:                         w_fmt = FMT_U;
            default:                                        w_fmt = FMT_BAD;
        endcase
    end
`else
    logic w_unused_op;
    assign w_unused_op = ^instr[6:0];

    always_comb begin
        w_fmt = FMT_BAD;
        case (imm_src)
            3'd0:    w_fmt = FMT_I;
            3'd1:    w_fmt = FMT_S;
            3'd2:    w_fmt = FMT_B;
            3'd3:    w_fmt = FMT_J;
            3'd4:    w_fmt = FMT_U;
            default: w_fmt = FMT_BAD;
        endcase
    end
`endif

    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   w_imm32 = {instr[31:12], 12'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Every format is already sign-correct at 32 bits, so widening is a plain sign extension.
    assign w_imm_ext = XLEN'($signed(w_imm32));

    assign in_ready  = (r_fill != FW'(DEPTH));
    assign out_valid = (r_fill != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign fill      = r_fill;
    assign err_cnt   = r_err_cnt;
    assign w_head    = r_mem[r_rd_ptr];

    // Head is gated so an empty FIFO never exposes stale or unwritten storage.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_imm_gate
            assign imm[gi] = out_valid & w_head[gi];
        end
    endgenerate
    assign imm_err = out_valid & w_head[XLEN];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {(w_fmt == FMT_BAD), w_imm_ext};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_push && (w_fmt == FMT_BAD) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_unit.sv
// Randomized bench for imm_gen_unit: two instances (XLEN=32/DEPTH=2, XLEN=64/DEPTH=4)
// checked every cycle against a queue-based reference model, plus directed literal checks.
module tb_imm_gen_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [2:0]  imm_src = 3'd0;

    logic        a_in_ready, a_out_valid, a_imm_err;
    logic [31:0] a_imm;
    logic [1:0]  a_fill;
    logic [7:0]  a_err_cnt;
    logic        b_in_ready, b_out_valid, b_imm_err;
    logic [63:0] b_imm;
    logic [2:0]  b_fill;
    logic [7:0]  b_err_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [64:0] q32[$];
    logic [64:0] q64[$];
    int          ec32 = 0;
    int          ec64 = 0;

    imm_gen_unit #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid), .out_ready(out_ready),
        .imm(a_imm), .imm_err(a_imm_err), .fill(a_fill), .err_cnt(a_err_cnt)
    );

    imm_gen_unit #(.XLEN(64), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(b_out_valid), .out_ready(out_ready),
        .imm(b_imm), .imm_err(b_imm_err), .fill(b_fill), .err_cnt(b_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Format as 0..4 for I,S,B,J,U; 7 for invalid.
    function automatic int cur_fmt();
`ifdef IMM_AUTO_DECODE_EN
        case (instr[6:0])
            7'h13, 7'h03, 7'h67, 7'h1B: return 0;
            7'h23:                      return 1;
            7'h63:                      return 2;
            7'h6F:                      return 3;
            7'h37, 7'h17:               return 4;
            default:                    return 7;
        endcase
`else
        return (imm_src <= 3'd4) ? int'(imm_src) : 7;
`endif
    endfunction

    function automatic logic [64:0] ref_entry(input logic [31:0] ins, input int fmt);
        longint v;
        case (fmt)
            0: v = longint'($signed(ins[31:20]));
            1: v = longint'($signed({ins[31:25], ins[11:7]}));
            2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            3: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            4: v = longint'($signed(ins[31:12])) * 4096;
            default: return {1'b1, 64'd0};
        endcase
        return {1'b0, 64'(v)};
    endfunction

    always @(posedge rst) begin
        q32.delete();
        q64.delete();
        ec32 = 0;
        ec64 = 0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            int          f;
            logic [64:0] e;
            bit          acc32, acc64;
            f = cur_fmt();
            e = ref_entry(instr, f);
            acc32 = in_valid && (q32.size() < 2);
            acc64 = in_valid && (q64.size() < 4);
            if (out_ready && q32.size() > 0) void'(q32.pop_front());
            if (out_ready && q64.size() > 0) void'(q64.pop_front());
            if (acc32) begin
                q32.push_back(e);
                if (f == 7 && ec32 < 255) ec32++;
            end
            if (acc64) begin
                q64.push_back(e);
                if (f == 7 && ec64 < 255) ec64++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            logic [64:0] h32, h64;
            h32 = (q32.size() != 0) ? q32[0] : 65'd0;
            h64 = (q64.size() != 0) ? q64[0] : 65'd0;
            chk("a_out_valid", 64'(a_out_valid), 64'(q32.size() != 0));
            chk("a_fill",      64'(a_fill),      64'(q32.size()));
            chk("a_in_ready",  64'(a_in_ready),  64'(q32.size() < 2));
            chk("a_imm",       64'(a_imm),       64'(h32[31:0]));
            chk("a_imm_err",   64'(a_imm_err),   64'(h32[64]));
            chk("a_err_cnt",   64'(a_err_cnt),   64'(ec32));
            chk("b_out_valid", 64'(b_out_valid), 64'(q64.size() != 0));
            chk("b_fill",      64'(b_fill),      64'(q64.size()));
            chk("b_in_ready",  64'(b_in_ready),  64'(q64.size() < 4));
            chk("b_imm",       b_imm,            h64[63:0]);
            chk("b_imm_err",   64'(b_imm_err),   64'(h64[64]));
            chk("b_err_cnt",   64'(b_err_cnt),   64'(ec64));
        end
    end

    task automatic push_one(input logic [31:0] ins, input logic [2:0] src);
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = src;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h00};

    initial begin
        // Model pins against hand-computed values.
        chk("model_I", ref_entry(32'hFFF00093, 0)[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_B", ref_entry(32'hFE000EE3, 2)[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_U", ref_entry(32'h800000B7, 4)[63:0], 64'hFFFF_FFFF_8000_0000);

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_fill",      64'(a_fill),      64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_imm",       64'(a_imm),       64'd0);
        chk("rst_err_cnt",   64'(a_err_cnt),   64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // I format, one-cycle latency from empty.
        push_one(32'hFFF00093, 3'd0);
        chk("i_valid", 64'(a_out_valid), 64'd1);
        chk("i_imm32", 64'(a_imm), 64'h0000_0000_FFFF_FFFF);
        chk("i_err",   64'(a_imm_err), 64'd0);
        chk("i_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        push_one(32'hFE000EE3, 3'd2);
        chk("b_fmt_imm32", 64'(a_imm), 64'h0000_0000_FFFF_FFFC);
        drain();

        // Back-pressure on the DEPTH=2 instance.
        push_one(32'h00500093, 3'd0);
        push_one(32'h00700093, 3'd0);
        chk("full_fill",     64'(a_fill), 64'd2);
        chk("full_in_ready", 64'(a_in_ready), 64'd0);
        push_one(32'h00900093, 3'd0);
        chk("blocked_fill",  64'(a_fill), 64'd2);
        out_ready = 1'b1;
        chk("pop_first",  64'(a_imm), 64'd5);
        @(negedge clk);
        chk("pop_second", 64'(a_imm), 64'd7);
        drain();

        push_one(32'h800000B7, 3'd4);
        chk("u_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("u_imm32", 64'(a_imm), 64'h0000_0000_8000_0000);
        drain();

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 1) == 1) r[6:0] = ops[$urandom_range(0, 9)];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = r;
            imm_src   = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Invalid flood: opcode 0 and imm_src=101 are invalid in either build.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            r[6:0] = 7'd0;
            in_valid = 1'b1;
            instr    = r;
            imm_src  = 3'd5;
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();
        chk("sat_a", 64'(a_err_cnt), 64'd255);
        chk("sat_b", 64'(b_err_cnt), 64'd255);

        // Asynchronous reset with no clock edge.
        push_one(32'h00500093, 3'd0);
        push_one(32'h00700093, 3'd0);
        chk("pre_rst_fill", 64'(a_fill), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_fill",      64'(a_fill),      64'd0);
        chk("arst_err_cnt",   64'(a_err_cnt),   64'd0);
        chk("arst_in_ready",  64'(a_in_ready),  64'd1);
        chk("arst_imm",       64'(a_imm),       64'd0);
        chk("arst_b_fill",    64'(b_fill),      64'd0);
        #1 rst = 1'b0;

        push_one(32'h00000023, 3'd7);
        chk("post_rst_valid", 64'(a_out_valid), 64'd1);
`ifdef IMM_AUTO_DECODE_EN
        chk("auto_s_imm", 64'(a_imm), 64'd0);
        chk("auto_s_err", 64'(a_imm_err), 64'd0);
`else
        chk("src7_err", 64'(a_imm_err), 64'd1);
`endif
        drain();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
